pkt_proc_sequencer: RTL and testbench
=====================================

// Module: pkt_proc_sequencer
// PURPOSE
//  Sequences the store-process-forward loop around the packet FIFO/SRAM and the RISC-V core.
//  Captures one packet into the FIFO, stalls ingress, and enables the core until it signals done.
//  Then drains the processed packet to the output port and rearms.
//  Sits between the header-parser/accelerator output, the FIFO/SRAM and the core's pc_en input.
// PARAMETERS
//  CNT_W           16    width of packet/word/timeout statistics counters
//  WDOG_W          16    width of processing watchdog counter
//  WDOG_CYCLES     4096  core cycles allowed per packet before forced drain
// PORTS
//  clk           in   1      core clock
//  reset_n       in   1      asynchronous active-low reset
//  sw_enable     in   1      software: 1 = sequenced mode, 0 = pass-through
//  sw_flush      in   1      software: abort current packet, flush FIFO (level; edge-detected)
//  in_wr         in   1      word written into FIFO this cycle
//  in_sop        in   1      qualifies in_wr: first word of packet
//  in_eop        in   1      qualifies in_wr: last word of packet
//  cpu_done      in   1      one-cycle pulse from core: packet processing complete
//  out_wr        in   1      word read out of FIFO this cycle
//  out_eop       in   1      qualifies out_wr: last word of packet
//  cpu_en        out  1      drives core pc_en
//  ingress_stall out  1      ORed into FIFO stall; blocks upstream writes
//  drain_en      out  1      gates FIFO read enable
//  fifo_flush    out  1      one-cycle pulse, ORed into FIFO reset
//  seq_state     out  2      current state encoding (hardware register)
//  pkt_len       out  CNT_W  word count of last captured packet
//  pkt_done_cnt  out  CNT_W  packets fully drained
//  timeout_cnt   out  CNT_W  watchdog expiries
// BEHAVIOUR
//  Reset: state IDLE; cpu_en=0, ingress_stall=0, drain_en=1, fifo_flush=0; all counters 0.
//  All outputs registered, except that seq_state reflects the state register directly.
//  IDLE (00): drain_en=1 (pass-through), stall=0, cpu_en=0.
//   - in_wr & in_sop & sw_enable -> FILL; word counter loads 1.
//   - Same cycle also has in_eop (1-word packet) -> PROC directly; pkt_len=1.
//  FILL (01): drain_en=0. Each in_wr increments word counter (saturates at all-ones).
//   - in_wr & in_eop -> PROC; pkt_len latches the final count.
//  PROC (10): cpu_en=1, ingress_stall=1, drain_en=0. cpu_done -> DRAIN.
//   - cpu_en deasserts the cycle after cpu_done is seen.
//  DRAIN (11): cpu_en=0, stall=1, drain_en=1.
//   - out_wr & out_eop -> IDLE; pkt_done_cnt++ (wraps).
//  Ingress stall rises one cycle after the eop write is accepted; FIFO almfull margin must cover >=1 word.
//  cpu_done outside PROC, in_sop outside IDLE, and out_eop outside DRAIN are ignored.
//  sw_enable is sampled only in IDLE; deassertion mid-packet completes the current packet first.
//  sw_flush rising edge: from any state -> IDLE next cycle; fifo_flush pulses 1 cycle.
//   - Counters are held; no pkt_done increment. Flush takes priority over every other transition.
//  Async reset mid-packet: immediate return to reset values; FIFO contents are the FIFO's own concern.
// CONFIGURATION
//  PKT_SEQ_WATCHDOG_EN defined:
//   - Watchdog counter clears on PROC entry and counts each PROC cycle.
//   - Reaching WDOG_CYCLES-1 without cpu_done forces DRAIN and increments timeout_cnt.
//   - cpu_done on the expiry cycle wins: no timeout is counted.
//  Not defined: no watchdog logic; PROC waits indefinitely; timeout_cnt tied to 0.
// STRUCTURE
//  pkt_seq_defs.vh (shared include): state encodings ST_IDLE/ST_FILL/ST_PROC/ST_DRAIN and register
//   bit positions used by software and generic_regs mapping.
//  One sub-module, proc_watchdog (WDOG_W counter, clear/enable, expire pulse); instantiated only under
//   PKT_SEQ_WATCHDOG_EN.
// TESTING
//  5-word pkt, sw_enable=1, cpu_done 20 cyc after PROC entry
//   -> state 00->01->10->11->00; pkt_len=5; pkt_done_cnt=1; cpu_en high exactly 20+1 cycles.
//  1-word pkt (sop & eop together) -> IDLE->PROC directly; pkt_len=1.
//  sw_enable=0, 3 back-to-back pkts -> stays IDLE; drain_en=1 throughout; cpu_en never asserts.
//  sw_flush edge while in PROC -> fifo_flush one pulse; next state IDLE; pkt_done_cnt unchanged;
//   a following pkt sequences normally.
//  Watchdog on, WDOG_CYCLES=16, no cpu_done -> DRAIN after 16 PROC cycles; timeout_cnt=1.
//   - cpu_done on cycle 16 -> timeout_cnt stays 0.
//  Stray cpu_done in IDLE and out_eop in FILL -> no state change, counters unchanged.

Source files
------------

// File: rtl/pkt_proc_sequencer_pkg.sv
// Shared definitions for the packet store/process/forward sequencer: state encodings
// and the software-visible register bit positions used by the generic_regs mapping.
package pkt_proc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_PROC  = 2'b10,
        ST_DRAIN = 2'b11
    } seq_state_e;

    // Control register bits (software writes)
    localparam int REG_CTRL_ENABLE_BIT = 0;
    localparam int REG_CTRL_FLUSH_BIT  = 1;
    // Status register field holding seq_state
    localparam int REG_STAT_STATE_LSB  = 0;
    localparam int REG_STAT_STATE_MSB  = 1;

    // FIFO read side is open while idle (pass-through) and while draining
    function automatic logic st_drains(input seq_state_e s);
        return (s == ST_IDLE) || (s == ST_DRAIN);
    endfunction

    // Upstream is held off from processing start until the packet has left
    function automatic logic st_stalls(input seq_state_e s);
        return (s == ST_PROC) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/proc_watchdog.sv
// Processing watchdog: counts cycles while enabled, clears on demand, and flags the
// cycle on which the count reaches WDOG_CYCLES-1.
module proc_watchdog #(
    parameter int WDOG_W      = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/pkt_proc_sequencer.sv
// Store-process-forward sequencer around the packet FIFO and the RISC-V core.
// Optional processing watchdog enabled by defining PKT_SEQ_WATCHDOG_EN.
module pkt_proc_sequencer
    import pkt_proc_sequencer_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WDOG_W      = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sw_enable,
    input  logic             sw_flush,
    input  logic             in_wr,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             cpu_done,
    input  logic             out_wr,
    input  logic             out_eop,
    output logic             cpu_en,
    output logic             ingress_stall,
    output logic             drain_en,
    output logic             fifo_flush,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] pkt_len,
    output logic [CNT_W-1:0] pkt_done_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    seq_state_e       r_state, w_next;
    logic             r_flush_d, w_flush_rise;
    logic             r_cpu_en, r_stall, r_drain, r_fifo_flush;
    logic [CNT_W-1:0] r_wcnt, w_wcnt_inc, w_wcnt_next;
    logic [CNT_W-1:0] r_pkt_len, r_done_cnt, r_tmo_cnt;
    logic             w_len_ld, w_done_inc, w_tmo_inc;
    logic             w_wdog_expire;

    assign w_flush_rise = sw_flush && !r_flush_d;
    assign w_wcnt_inc   = (&r_wcnt) ? r_wcnt : r_wcnt + 1'b1;

`ifdef PKT_SEQ_WATCHDOG_EN
    proc_watchdog #(
        .WDOG_W      (WDOG_W),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (r_state != ST_PROC),
        .i_en     (r_state == ST_PROC),
        .o_expire (w_wdog_expire)
    );
`else
    // No watchdog: the expression is constant 0 for any legal configuration
    assign w_wdog_expire = (WDOG_CYCLES == 0) && (WDOG_W == 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_wcnt_next = r_wcnt;
        w_len_ld    = 1'b0;
        w_done_inc  = 1'b0;
        w_tmo_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_wr && in_sop && sw_enable) begin
                    w_wcnt_next = CNT_W'(1);
                    if (in_eop) begin
                        w_next   = ST_PROC;
                        w_len_ld = 1'b1;
                    end else begin
                        w_next = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (in_wr) begin
                    w_wcnt_next = w_wcnt_inc;
                    if (in_eop) begin
                        w_next   = ST_PROC;
                        w_len_ld = 1'b1;
                    end
                end
            end
            ST_PROC: begin
                // cpu_done on the expiry cycle is a normal completion
                if (cpu_done) begin
                    w_next = ST_DRAIN;
                end else if (w_wdog_expire) begin
                    w_next    = ST_DRAIN;
                    w_tmo_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_wr && out_eop) begin
                    w_next     = ST_IDLE;
                    w_done_inc = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_flush_rise) begin
            w_next      = ST_IDLE;
            w_wcnt_next = r_wcnt;
            w_len_ld    = 1'b0;
            w_done_inc  = 1'b0;
            w_tmo_inc   = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with seq_state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_d    <= 1'b0;
            r_cpu_en     <= 1'b0;
            r_stall      <= 1'b0;
            r_drain      <= 1'b1;
            r_fifo_flush <= 1'b0;
        end else begin
            r_flush_d    <= sw_flush;
            r_cpu_en     <= (w_next == ST_PROC);
            r_stall      <= st_stalls(w_next);
            r_drain      <= st_drains(w_next);
            r_fifo_flush <= w_flush_rise;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt     <= '0;
            r_pkt_len  <= '0;
            r_done_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_wcnt <= w_wcnt_next;
            if (w_len_ld) begin
                r_pkt_len <= w_wcnt_next;
            end
            if (w_done_inc) begin
                r_done_cnt <= r_done_cnt + 1'b1;
            end
            if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign cpu_en        = r_cpu_en;
    assign ingress_stall = r_stall;
    assign drain_en      = r_drain;
    assign fifo_flush    = r_fifo_flush;
    assign seq_state     = r_state;
    assign pkt_len       = r_pkt_len;
    assign pkt_done_cnt  = r_done_cnt;
    assign timeout_cnt   = r_tmo_cnt;

endmodule

// File: tb/tb_pkt_proc_sequencer.sv
// Randomized transaction-level bench for pkt_proc_sequencer; expectations come from
// per-packet arithmetic (lengths, done/timeout counts, cpu_en cycle totals).
module tb_pkt_proc_sequencer;

    localparam int CNT_W       = 16;
    localparam int WDOG_W      = 16;
    localparam int WDOG_CYCLES = 16;
`ifdef PKT_SEQ_WATCHDOG_EN
    localparam int DMAX = WDOG_CYCLES - 1;
    localparam int D20  = 10;
`else
    localparam int DMAX = 30;
    localparam int D20  = 20;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sw_enable = 1'b0, sw_flush = 1'b0;
    logic in_wr = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic cpu_done = 1'b0, out_wr = 1'b0, out_eop = 1'b0;
    logic cpu_en, ingress_stall, drain_en, fifo_flush;
    logic [1:0]       seq_state;
    logic [CNT_W-1:0] pkt_len, pkt_done_cnt, timeout_cnt;

    pkt_proc_sequencer #(
        .CNT_W(CNT_W), .WDOG_W(WDOG_W), .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sw_enable(sw_enable), .sw_flush(sw_flush),
        .in_wr(in_wr), .in_sop(in_sop), .in_eop(in_eop), .cpu_done(cpu_done),
        .out_wr(out_wr), .out_eop(out_eop), .cpu_en(cpu_en), .ingress_stall(ingress_stall),
        .drain_en(drain_en), .fifo_flush(fifo_flush), .seq_state(seq_state),
        .pkt_len(pkt_len), .pkt_done_cnt(pkt_done_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cpu_en_cycles = 0;
    int exp_len = 0, exp_done = 0, exp_tmo = 0;

    always @(negedge clk) if (cpu_en) cpu_en_cycles++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_len"},  32'(pkt_len),      32'(exp_len));
        chk({tag, "_done"}, 32'(pkt_done_cnt), 32'(exp_done));
        chk({tag, "_tmo"},  32'(timeout_cnt),  32'(exp_tmo));
    endtask

    task automatic chk_outs(input string tag, input int st, input bit cen, input bit stl, input bit drn);
        chk({tag, "_state"}, 32'(seq_state), 32'(st));
        chk({tag, "_cpu_en"}, 32'(cpu_en), 32'(cen));
        chk({tag, "_stall"}, 32'(ingress_stall), 32'(stl));
        chk({tag, "_drain"}, 32'(drain_en), 32'(drn));
    endtask

    // Capture a packet of len words; leaves the DUT in the processing phase
    task automatic fill_pkt(input int len, input bit drop_en, input bit stray);
        sw_enable = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                in_wr = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
                tick;
                chk("fill_gap_state", 32'(seq_state), 32'd1);
            end
            in_wr  = 1'b1;
            in_sop = (i == 0) || ($urandom_range(0, 4) == 0);
            in_eop = (i == len - 1);
            if (stray && i == 1 && i < len - 1) begin
                out_wr = 1'b1; out_eop = 1'b1;
            end
            tick;
            out_wr = 1'b0; out_eop = 1'b0;
            if (drop_en) sw_enable = 1'b0;
            if (i < len - 1) chk_outs("fill", 1, 0, 0, 0);
        end
        in_wr = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        exp_len = len;
        chk_outs("proc_entry", 2, 1, 1, 0);
        chk_cnts("proc_entry");
    endtask

    task automatic drain_pkt(input int dlen);
        for (int j = 0; j < dlen; j++) begin
            if ($urandom_range(0, 2) == 0) begin
                out_wr = 1'b0; out_eop = 1'b1;
                tick;
                chk("drain_noeop_state", 32'(seq_state), 32'd3);
            end
            out_wr = 1'b1; out_eop = (j == dlen - 1);
            tick;
            if (j < dlen - 1) chk("drain_state", 32'(seq_state), 32'd3);
        end
        out_wr = 1'b0; out_eop = 1'b0;
        exp_done++;
        chk_outs("idle_after", 0, 0, 0, 1);
        chk_cnts("idle_after");
    endtask

    // delay < 0 lets the watchdog end processing
    task automatic seq_pkt(input int len, input int delay, input int dlen, input bit drop_en, input bit stray);
        int c0;
        fill_pkt(len, drop_en, stray);
        c0 = cpu_en_cycles;
        if (delay < 0) begin
            repeat (WDOG_CYCLES - 1) tick;
            chk("wdog_last_state", 32'(seq_state), 32'd2);
            tick;
            exp_tmo++;
            chk("wdog_cpu_en_cycles", 32'(cpu_en_cycles - c0), 32'(WDOG_CYCLES));
        end else begin
            repeat (delay) tick;
            cpu_done = 1'b1;
            tick;
            cpu_done = 1'b0;
            chk("cpu_en_cycles", 32'(cpu_en_cycles - c0), 32'(delay + 1));
        end
        chk_outs("drain_entry", 3, 0, 1, 1);
        chk_cnts("drain_entry");
        drain_pkt(dlen);
    endtask

    task automatic pass_pkt(input int len);
        int c0;
        c0 = cpu_en_cycles;
        sw_enable = 1'b0;
        for (int i = 0; i < len; i++) begin
            in_wr = 1'b1; in_sop = (i == 0); in_eop = (i == len - 1);
            tick;
            chk_outs("pass", 0, 0, 0, 1);
        end
        in_wr = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        chk("pass_cpu_en_cycles", 32'(cpu_en_cycles - c0), 32'd0);
        chk_cnts("pass");
    endtask

    // Flush rising edge (level held one extra cycle) with competing events in the same cycle
    task automatic flush_now;
        sw_flush = 1'b1;
        out_wr = 1'b1; out_eop = 1'b1; cpu_done = 1'b1; in_wr = 1'b1; in_eop = 1'b1;
        tick;
        out_wr = 1'b0; out_eop = 1'b0; cpu_done = 1'b0; in_wr = 1'b0; in_eop = 1'b0;
        chk("flush_pulse", 32'(fifo_flush), 32'd1);
        chk_outs("flush", 0, 0, 0, 1);
        chk_cnts("flush");
        tick;
        chk("flush_single_pulse", 32'(fifo_flush), 32'd0);
        chk("flush_held_state", 32'(seq_state), 32'd0);
        sw_flush = 1'b0;
        tick;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 1);
        chk("reset_flush", 32'(fifo_flush), 32'd0);
        chk_cnts("reset");
        reset_n = 1'b1;
        tick;

        // 5-word packet, cpu_done 20 cycles after processing starts
        seq_pkt(5, D20, 4, 1'b0, 1'b0);
        // single-word packet goes straight to processing
        seq_pkt(1, 3, 1, 1'b0, 1'b0);
        // three back-to-back packets in pass-through mode
        pass_pkt(3); pass_pkt(1); pass_pkt(4);

        // stray cpu_done / out_eop in IDLE
        sw_enable = 1'b1;
        cpu_done = 1'b1; out_wr = 1'b1; out_eop = 1'b1;
        tick;
        cpu_done = 1'b0; out_wr = 1'b0; out_eop = 1'b0;
        chk_outs("stray_idle", 0, 0, 0, 1);
        chk_cnts("stray_idle");
        // stray out_eop during FILL, enable dropped mid-packet
        seq_pkt(4, 2, 2, 1'b1, 1'b1);

        // flush while processing, then in FILL, then in DRAIN
        fill_pkt(3, 1'b0, 1'b0);
        repeat (2) tick;
        flush_now;
        seq_pkt(2, 1, 2, 1'b0, 1'b0);
        sw_enable = 1'b1; in_wr = 1'b1; in_sop = 1'b1;
        tick;
        in_sop = 1'b0;
        flush_now;
        fill_pkt(2, 1'b0, 1'b0);
        cpu_done = 1'b1;
        tick;
        cpu_done = 1'b0;
        flush_now;

`ifdef PKT_SEQ_WATCHDOG_EN
        seq_pkt(3, -1, 2, 1'b0, 1'b0);
        seq_pkt(2, WDOG_CYCLES - 1, 1, 1'b0, 1'b0);
`else
        fill_pkt(2, 1'b0, 1'b0);
        repeat (40) tick;
        chk("no_wdog_state", 32'(seq_state), 32'd2);
        chk("no_wdog_tmo", 32'(timeout_cnt), 32'd0);
        cpu_done = 1'b1;
        tick;
        cpu_done = 1'b0;
        drain_pkt(1);
`endif

        repeat (12) begin
            if ($urandom_range(0, 2) != 0)
                seq_pkt($urandom_range(1, 8), $urandom_range(0, DMAX), $urandom_range(1, 6),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                pass_pkt($urandom_range(1, 6));
        end

        // async reset in the middle of a packet
        sw_enable = 1'b1; in_wr = 1'b1; in_sop = 1'b1;
        tick;
        in_wr = 1'b0; in_sop = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        exp_len = 0; exp_done = 0; exp_tmo = 0;
        chk_outs("async_reset", 0, 0, 0, 1);
        chk_cnts("async_reset");
        tick;
        reset_n = 1'b1;
        tick;
        seq_pkt(1, 0, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
